can_rx_framer: RTL and testbench
================================

Name: can_rx_framer

Overview:
- Receive-side stage directly downstream of the CAN transmit node.
- Consumes one sampled bus bit per bit time and removes stuff bits.
- Checks standard-format frame structure and CRC-15.
- Presents the decoded ID, DLC and data as one frame record with a single-cycle valid strobe for the PROCESS logic and UART logging.

Parameters:
- MAX_BYTES, 8, maximum data bytes captured; a DLC above this is clamped to it.
- IDLE_BITS, 7, consecutive recessive bits needed to declare the bus idle after an error.

Ports:
- can_clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- bit_valid  input  1  one-cycle strobe marking the sample point of one bus bit.
- rx_bit  input  1  sampled can_lo level (0 = dominant, 1 = recessive).
- frame_valid  output  1  one-cycle pulse when a complete, error-free frame has been received.
- frame_id  output  11  identifier of the last good frame.
- frame_rtr  output  1  RTR bit of the last good frame.
- frame_dlc  output  4  raw DLC field as received.
- frame_data  output  64  data bytes; byte0 in [7:0]; unused bytes are 0.
- crc_err  output  1  one-cycle pulse on CRC mismatch.
- stuff_err  output  1  one-cycle pulse on a stuff violation.
- form_err  output  1  one-cycle pulse on a fixed-form field violation, or when IDE=1 (extended format not supported).
- busy  output  1  high from SOF until frame end, or until idle is recovered after an error.
- ack_out  output  1  ACK drive to the bus (0 = dominant).

Behaviour:
- Reset state: all outputs are 0 except ack_out=1. FSM goes to IDLE and all counters clear.
- Every state advances only on a cycle with bit_valid=1; otherwise all state is held.
- States and transitions:
  - IDLE: rx_bit=0 is SOF. Go to ARB, set busy, clear the shift register and CRC, set stuff count to 1 with last bit 0.
  - ARB: 11 ID bits MSB-first, then RTR. Go to CTRL.
  - CTRL: IDE, r0, then 4 DLC bits. IDE=1 raises form_err and goes to ERR.
  - Data byte count = 0 if RTR=1, else min(DLC, MAX_BYTES). Count 0 goes straight to CRC, otherwise to DATA.
  - DATA: count×8 bits MSB-first per byte. Byte k is written to frame_data[8k+:8]. Go to CRC.
  - CRC: 15 bits compared against the running CRC. Go to CRC_DEL.
  - CRC_DEL: bit must be 1, else form_err and ERR.
  - ACK_SLOT: any value accepted.
  - ACK_DEL: bit must be 1, else form_err.
  - EOF: 7 bits, all must be 1, else form_err.
  - After the 7th EOF bit: if CRC matched, pulse frame_valid for one cycle; otherwise pulse crc_err. busy drops and the FSM returns to IDLE.
- Destuffing:
  - Active from SOF through the last CRC bit.
  - After 5 equal consecutive bits, the next bit is a stuff bit. It is discarded and not fed to the CRC.
  - If the stuff bit equals the previous bit, pulse stuff_err and go to ERR.
  - A stuff bit restarts the run count at 1 with its own value.
- CRC-15: polynomial 15'h4599, init 0, computed over the destuffed bits from SOF through the last data bit. The comparison happens after CRC bit 15; crc_err is reported at frame end, not immediately.
- ERR: wait for IDLE_BITS consecutive recessive bits, then go to IDLE. A dominant bit restarts the count. busy stays high.
- Error pulses are one cycle wide, and at most one error is reported per frame.
- frame_id, frame_rtr, frame_dlc and frame_data are staging-registered and copied to the outputs only in the frame_valid cycle. They hold until the next good frame.
- A bit_valid arriving in the same cycle as frame_valid is evaluated as the IDLE state.

Optional Feature:
- CAN_RX_ACK_EN defined: ack_out=0 (dominant) for exactly the ACK_SLOT bit time, starting the cycle after the CRC_DEL bit_valid and ending with the ACK_SLOT bit_valid, only if the CRC matched and no error occurred.
- CAN_RX_ACK_EN undefined: ack_out is tied to 1.

Decomposition:
- Package can_pkg holds:
  - the state encoding: IDLE, ARB, CTRL, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, ERR;
  - CRC15_POLY=15'h4599;
  - field lengths ID_LEN=11, DLC_LEN=4, CRC_LEN=15, EOF_LEN=7;
  - STUFF_LIMIT=5.
- The package is shared with the transmit node.
- Sub-module can_crc15: serial CRC register with clear, enable, bit-in and crc[14:0] out. It is reused by the transmitter.

Test Plan:
- Good frame, ID 0x123, DLC 1, data 0x89, correct CRC, stuffing applied → one frame_valid pulse; frame_id=0x123, frame_dlc=1, frame_data=64'h89; no error pulses.
- Same frame with one CRC bit flipped → crc_err pulse at frame end; frame_valid stays 0; previous outputs unchanged.
- Six equal bits inside ID 0x000 (stuff bit forced equal) → stuff_err, then busy stays high until 7 recessive bits, then return to IDLE.
- DLC=4'hF with 8 data bytes 0x01..0x08 → frame_dlc=0xF; frame_data=64'h0807060504030201; frame_valid.
- RTR=1, DLC=2, no data bytes → frame_valid with frame_rtr=1 and frame_data=0. Second check: an EOF bit driven to 0 → form_err.
- Reset asserted mid-DATA → immediate IDLE; busy=0; ack_out=1. The next frame decodes correctly. With CAN_RX_ACK_EN defined, ack_out=0 for exactly one bit time.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN definitions: frame FSM state encoding, CRC-15 polynomial and
// standard-format field lengths, used by both the receive framer and the transmit node.
package can_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ARB,
      CTRL,
      DATA,
      CRC,
      CRC_DEL,
      ACK_SLOT,
      ACK_DEL,
      EOF,
      ERR
   } can_state_t;

   localparam logic [14:0] CRC15_POLY = 15'h4599;

   localparam int ID_LEN      = 11;
   localparam int DLC_LEN     = 4;
   localparam int CRC_LEN     = 15;
   localparam int EOF_LEN     = 7;
   localparam int STUFF_LIMIT = 5;

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 register: one bit shifted in per enable, synchronous clear
// has priority over enable. Shared between the receive framer and the transmitter.
module can_crc15
   import can_pkg::*;
(
   input  logic               can_clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic               bit_in,
   output logic [CRC_LEN-1:0] crc
);

   logic               feedback;
   logic [CRC_LEN-1:0] shifted;

   assign feedback = bit_in ^ crc[CRC_LEN-1];
   assign shifted  = {crc[CRC_LEN-2:0], 1'b0};

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge can_clk or posedge reset) begin
      if (reset) begin
         crc <= '0;
      end else if (clear) begin
         crc <= '0;
      end else if (enable) begin
         crc <= feedback ? (shifted ^ CRC15_POLY) : shifted;
      end
   end

endmodule

// File: rtl/can_rx_framer.sv
// CAN standard-format receive framer: destuffs, checks form and CRC-15, and
// publishes a frame record with a one-cycle valid. `define CAN_RX_ACK_EN drives ACK.
module can_rx_framer
   import can_pkg::*;
#(
   parameter int MAX_BYTES = 8,
   parameter int IDLE_BITS = 7
) (
   input  logic        can_clk,
   input  logic        reset,
   input  logic        bit_valid,
   input  logic        rx_bit,
   output logic        frame_valid,
   output logic [10:0] frame_id,
   output logic        frame_rtr,
   output logic [3:0]  frame_dlc,
   output logic [63:0] frame_data,
   output logic        crc_err,
   output logic        stuff_err,
   output logic        form_err,
   output logic        busy,
   output logic        ack_out
);

   localparam int                IDLE_W    = $clog2(IDLE_BITS + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);
   localparam logic [3:0]        MAX_B4    = 4'(MAX_BYTES);

   can_state_t          state;
   logic [6:0]          bit_cnt;
   logic [2:0]          stuff_cnt;
   logic                last_bit;
   logic [IDLE_W-1:0]   idle_cnt;

   logic [ID_LEN-1:0]   id_stage;
   logic                rtr_stage;
   logic [DLC_LEN-1:0]  dlc_stage;
   logic [63:0]         data_stage;
   logic [3:0]          byte_cnt;
   logic [CRC_LEN-1:0]  crc_rx;
   logic                crc_ok;

   logic [CRC_LEN-1:0]  crc_calc;
   logic                destuff_active;
   logic                is_stuff;
   logic                crc_clear;
   logic                crc_en;
   logic [DLC_LEN-1:0]  dlc_next;
   logic [3:0]          byte_cnt_next;
   logic [6:0]          data_last_idx;
   logic [CRC_LEN-1:0]  crc_rx_next;

   assign destuff_active = state inside {ARB, CTRL, DATA, CRC};
   assign is_stuff       = destuff_active && (stuff_cnt == 3'(STUFF_LIMIT));
   // SOF is a dominant bit into a zero register, so clearing equals feeding it.
   assign crc_clear      = bit_valid && (state == IDLE) && !rx_bit;
   assign crc_en         = bit_valid && !is_stuff && (state inside {ARB, CTRL, DATA});
   assign dlc_next       = {dlc_stage[DLC_LEN-2:0], rx_bit};
   assign data_last_idx  = {byte_cnt, 3'b000} - 7'd1;
   assign crc_rx_next    = {crc_rx[CRC_LEN-2:0], rx_bit};

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      byte_cnt_next = 4'd0;
      if (!rtr_stage) begin
         byte_cnt_next = (dlc_next > MAX_B4) ? MAX_B4 : dlc_next;
      end
   end

   can_crc15 u_crc (
      .can_clk (can_clk),
      .reset   (reset),
      .clear   (crc_clear),
      .enable  (crc_en),
      .bit_in  (rx_bit),
      .crc     (crc_calc)
   );

   always_ff @(posedge can_clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         stuff_cnt   <= '0;
         last_bit    <= 1'b0;
         idle_cnt    <= '0;
         id_stage    <= '0;
         rtr_stage   <= 1'b0;
         dlc_stage   <= '0;
         // NOTE: the data staging register is reset because unused bytes must read as zero.
         data_stage  <= '0;
         byte_cnt    <= '0;
         crc_rx      <= '0;
         crc_ok      <= 1'b0;
         frame_valid <= 1'b0;
         frame_id    <= '0;
         frame_rtr   <= 1'b0;
         frame_dlc   <= '0;
         frame_data  <= '0;
         crc_err     <= 1'b0;
         stuff_err   <= 1'b0;
         form_err    <= 1'b0;
         busy        <= 1'b0;
`ifdef CAN_RX_ACK_EN
         ack_out     <= 1'b1;
`endif
      end else begin
         frame_valid <= 1'b0;
         crc_err     <= 1'b0;
         stuff_err   <= 1'b0;
         form_err    <= 1'b0;
         if (bit_valid) begin
            if (is_stuff) begin
               if (rx_bit == last_bit) begin
                  stuff_err <= 1'b1;
                  idle_cnt  <= '0;
                  state     <= ERR;
               end else begin
                  stuff_cnt <= 3'd1;
                  last_bit  <= rx_bit;
               end
            end else begin
               if (destuff_active) begin
                  stuff_cnt <= (rx_bit == last_bit) ? stuff_cnt + 3'd1 : 3'd1;
                  last_bit  <= rx_bit;
               end
               case (state)
                  IDLE: begin
                     if (!rx_bit) begin
                        state      <= ARB;
                        busy       <= 1'b1;
                        bit_cnt    <= '0;
                        stuff_cnt  <= 3'd1;
                        last_bit   <= 1'b0;
                        id_stage   <= '0;
                        rtr_stage  <= 1'b0;
                        dlc_stage  <= '0;
                        data_stage <= '0;
                        crc_rx     <= '0;
                        crc_ok     <= 1'b0;
                     end
                  end
                  ARB: begin
                     if (bit_cnt == 7'(ID_LEN)) begin
                        rtr_stage <= rx_bit;
                        bit_cnt   <= '0;
                        state     <= CTRL;
                     end else begin
                        id_stage <= {id_stage[ID_LEN-2:0], rx_bit};
                        bit_cnt  <= bit_cnt + 7'd1;
                     end
                  end
                  CTRL: begin
                     bit_cnt <= bit_cnt + 7'd1;
                     if (bit_cnt == 7'd0 && rx_bit) begin
                        form_err <= 1'b1;
                        idle_cnt <= '0;
                        state    <= ERR;
                     end else if (bit_cnt >= 7'd2) begin
                        dlc_stage <= dlc_next;
                        if (bit_cnt == 7'(DLC_LEN + 1)) begin
                           bit_cnt  <= '0;
                           byte_cnt <= byte_cnt_next;
                           state    <= (byte_cnt_next == 4'd0) ? CRC : DATA;
                        end
                     end
                  end
                  DATA: begin
                     // Bytes arrive MSB-first, so the bit offset within a byte is inverted.
                     data_stage[{bit_cnt[5:3], ~bit_cnt[2:0]}] <= rx_bit;
                     if (bit_cnt == data_last_idx) begin
                        bit_cnt <= '0;
                        state   <= CRC;
                     end else begin
                        bit_cnt <= bit_cnt + 7'd1;
                     end
                  end
                  CRC: begin
                     crc_rx <= crc_rx_next;
                     if (bit_cnt == 7'(CRC_LEN - 1)) begin
                        crc_ok  <= (crc_rx_next == crc_calc);
                        bit_cnt <= '0;
                        state   <= CRC_DEL;
                     end else begin
                        bit_cnt <= bit_cnt + 7'd1;
                     end
                  end
                  CRC_DEL: begin
                     if (!rx_bit) begin
                        form_err <= 1'b1;
                        idle_cnt <= '0;
                        state    <= ERR;
                     end else begin
                        state <= ACK_SLOT;
`ifdef CAN_RX_ACK_EN
                        ack_out <= !crc_ok;
`endif
                     end
                  end
                  ACK_SLOT: begin
                     state <= ACK_DEL;
`ifdef CAN_RX_ACK_EN
                     ack_out <= 1'b1;
`endif
                  end
                  ACK_DEL: begin
                     bit_cnt <= '0;
                     if (!rx_bit) begin
                        form_err <= 1'b1;
                        idle_cnt <= '0;
                        state    <= ERR;
                     end else begin
                        state <= EOF;
                     end
                  end
                  EOF: begin
                     if (!rx_bit) begin
                        form_err <= 1'b1;
                        idle_cnt <= '0;
                        state    <= ERR;
                     end else if (bit_cnt == 7'(EOF_LEN - 1)) begin
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        if (crc_ok) begin
                           frame_valid <= 1'b1;
                           frame_id    <= id_stage;
                           frame_rtr   <= rtr_stage;
                           frame_dlc   <= dlc_stage;
                           frame_data  <= data_stage;
                        end else begin
                           crc_err <= 1'b1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 7'd1;
                     end
                  end
                  ERR: begin
                     if (!rx_bit) begin
                        idle_cnt <= '0;
                     end else if (idle_cnt == IDLE_LAST) begin
                        idle_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                     end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

`ifndef CAN_RX_ACK_EN
   assign ack_out = 1'b1;
`endif

endmodule

// File: tb/tb_can_rx_framer.sv
// Directed bench for can_rx_framer: a small transmitter model builds stuffed
// frames; decoded fields and pulse counts are compared with hand-chosen values.
module tb_can_rx_framer;

   localparam int BIT_CYC = 4;
`ifdef CAN_RX_ACK_EN
   localparam int ACK_LOW = BIT_CYC;
`else
   localparam int ACK_LOW = 0;
`endif

   logic        can_clk = 1'b0;
   logic        reset;
   logic        bit_valid;
   logic        rx_bit;
   logic        frame_valid;
   logic [10:0] frame_id;
   logic        frame_rtr;
   logic [3:0]  frame_dlc;
   logic [63:0] frame_data;
   logic        crc_err;
   logic        stuff_err;
   logic        form_err;
   logic        busy;
   logic        ack_out;

   int checks = 0;
   int errors = 0;

   int fv_total = 0, crc_total = 0, stuff_total = 0, form_total = 0, ack_low_total = 0;
   int fv_base, crc_base, stuff_base, form_base, ack_base;

   bit tx_q[$];

   can_rx_framer dut (
      .can_clk     (can_clk),
      .reset       (reset),
      .bit_valid   (bit_valid),
      .rx_bit      (rx_bit),
      .frame_valid (frame_valid),
      .frame_id    (frame_id),
      .frame_rtr   (frame_rtr),
      .frame_dlc   (frame_dlc),
      .frame_data  (frame_data),
      .crc_err     (crc_err),
      .stuff_err   (stuff_err),
      .form_err    (form_err),
      .busy        (busy),
      .ack_out     (ack_out)
   );

   always #5 can_clk = ~can_clk;

   always @(negedge can_clk) begin
      if (frame_valid) fv_total <= fv_total + 1;
      if (crc_err)     crc_total <= crc_total + 1;
      if (stuff_err)   stuff_total <= stuff_total + 1;
      if (form_err)    form_total <= form_total + 1;
      if (!ack_out)    ack_low_total <= ack_low_total + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_cnt(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      fv_base    = fv_total;
      crc_base   = crc_total;
      stuff_base = stuff_total;
      form_base  = form_total;
      ack_base   = ack_low_total;
   endtask

   task automatic send_bit(input logic b);
      @(negedge can_clk);
      rx_bit    = b;
      bit_valid = 1'b1;
      @(negedge can_clk);
      bit_valid = 1'b0;
      repeat (BIT_CYC - 2) @(negedge can_clk);
   endtask

   task automatic send_idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   task automatic send_range(input int first, input int last);
      for (int k = first; k <= last; k++) send_bit(tx_q[k]);
   endtask

   // Transmitter model: raw fields, CRC-15 over SOF..data, stuffing SOF..CRC, trailer, 3 idle bits.
   task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                              input logic [63:0] data, input bit flip_crc, input bit bad_eof);
      bit          raw[$];
      logic [14:0] crc;
      logic        nxt;
      bit          last;
      int          run, nbytes;
      raw.push_back(1'b0);
      for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
      raw.push_back(rtr);
      raw.push_back(1'b0);
      raw.push_back(1'b0);
      for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
      nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
      for (int b = 0; b < nbytes; b++)
         for (int i = 7; i >= 0; i--) raw.push_back(data[8*b+i]);
      crc = '0;
      for (int k = 0; k < raw.size(); k++) begin
         nxt = raw[k] ^ crc[14];
         crc = {crc[13:0], 1'b0};
         if (nxt) crc = crc ^ 15'h4599;
      end
      if (flip_crc) crc[0] = ~crc[0];
      for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
      tx_q.delete();
      run  = 0;
      last = 1'b0;
      for (int k = 0; k < raw.size(); k++) begin
         tx_q.push_back(raw[k]);
         run  = (k == 0 || raw[k] != last) ? 1 : run + 1;
         last = raw[k];
         if (run == 5 && k != raw.size() - 1) begin
            tx_q.push_back(~raw[k]);
            last = ~raw[k];
            run  = 1;
         end
      end
      for (int i = 0; i < 3; i++) tx_q.push_back(1'b1);
      for (int i = 0; i < 7; i++) tx_q.push_back((bad_eof && i == 3) ? 1'b0 : 1'b1);
      for (int i = 0; i < 3; i++) tx_q.push_back(1'b1);
   endtask

   initial begin
      reset     = 1'b1;
      bit_valid = 1'b0;
      rx_bit    = 1'b1;
      repeat (3) @(negedge can_clk);
      reset = 1'b0;
      @(negedge can_clk);

      // Reset state
      check("rst_frame_valid", 64'(frame_valid), 64'd0);
      check("rst_frame_id", 64'(frame_id), 64'd0);
      check("rst_frame_data", frame_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ack_out", 64'(ack_out), 64'd1);
      check("rst_errs", 64'({crc_err, stuff_err, form_err}), 64'd0);

      // Good frame 0x123 / DLC 1 / 0x89
      build_frame(11'h123, 1'b0, 4'd1, 64'h89, 1'b0, 1'b0);
      snap();
      send_bit(tx_q[0]);
      check("good_busy_after_sof", 64'(busy), 64'd1);
      send_range(1, tx_q.size() - 1);
      check_cnt("good_fv_pulses", fv_total - fv_base, 1);
      check_cnt("good_err_pulses", (crc_total - crc_base) + (stuff_total - stuff_base) + (form_total - form_base), 0);
      check("good_id", 64'(frame_id), 64'h123);
      check("good_rtr", 64'(frame_rtr), 64'd0);
      check("good_dlc", 64'(frame_dlc), 64'd1);
      check("good_data", frame_data, 64'h89);
      check("good_busy_end", 64'(busy), 64'd0);
      check_cnt("good_ack_low_cycles", ack_low_total - ack_base, ACK_LOW);

      // Same frame with one CRC bit flipped
      build_frame(11'h123, 1'b0, 4'd1, 64'h89, 1'b1, 1'b0);
      snap();
      send_range(0, tx_q.size() - 1);
      check_cnt("crcbad_crc_err", crc_total - crc_base, 1);
      check_cnt("crcbad_fv", fv_total - fv_base, 0);
      check_cnt("crcbad_other_err", (stuff_total - stuff_base) + (form_total - form_base), 0);
      check("crcbad_id_held", 64'(frame_id), 64'h123);
      check("crcbad_data_held", frame_data, 64'h89);
      check_cnt("crcbad_no_ack", ack_low_total - ack_base, 0);

      // Stuff violation inside ID 0x000: SOF + 5 dominant bits
      snap();
      for (int i = 0; i < 6; i++) send_bit(1'b0);
      check_cnt("stuff_err_pulse", stuff_total - stuff_base, 1);
      check("stuff_busy_err", 64'(busy), 64'd1);
      send_idle(3);
      send_bit(1'b0);
      send_idle(6);
      check("stuff_busy_6rec", 64'(busy), 64'd1);
      send_idle(1);
      check("stuff_busy_idle", 64'(busy), 64'd0);
      check_cnt("stuff_single_err", (stuff_total - stuff_base) + (form_total - form_base) + (crc_total - crc_base), 1);

      // DLC 0xF clamped to 8 bytes
      build_frame(11'h2A5, 1'b0, 4'hF, 64'h0807060504030201, 1'b0, 1'b0);
      snap();
      send_range(0, tx_q.size() - 1);
      check_cnt("dlcf_fv", fv_total - fv_base, 1);
      check("dlcf_id", 64'(frame_id), 64'h2A5);
      check("dlcf_dlc", 64'(frame_dlc), 64'hF);
      check("dlcf_data", frame_data, 64'h0807060504030201);

      // RTR frame, DLC 2, no data
      build_frame(11'h456, 1'b1, 4'd2, 64'h0, 1'b0, 1'b0);
      snap();
      send_range(0, tx_q.size() - 1);
      check_cnt("rtr_fv", fv_total - fv_base, 1);
      check("rtr_flag", 64'(frame_rtr), 64'd1);
      check("rtr_dlc", 64'(frame_dlc), 64'd2);
      check("rtr_data_zero", frame_data, 64'd0);

      // EOF bit dominant: 6 recessive bits follow in the stream, one more recovers idle
      build_frame(11'h456, 1'b1, 4'd2, 64'h0, 1'b0, 1'b1);
      snap();
      send_range(0, tx_q.size() - 1);
      check_cnt("eof_form_err", form_total - form_base, 1);
      check_cnt("eof_fv", fv_total - fv_base, 0);
      check_cnt("eof_crc_err", crc_total - crc_base, 0);
      check("eof_busy_6rec", 64'(busy), 64'd1);
      send_idle(1);
      check("eof_busy_idle", 64'(busy), 64'd0);

      // Reset in the middle of the data field, then a clean frame
      build_frame(11'h123, 1'b0, 4'd1, 64'h89, 1'b0, 1'b0);
      send_range(0, 23);
      check("mid_busy_before_rst", 64'(busy), 64'd1);
      @(negedge can_clk);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_ack", 64'(ack_out), 64'd1);
      check("mid_rst_id_clear", 64'(frame_id), 64'd0);
      @(negedge can_clk);
      reset = 1'b0;
      build_frame(11'h7F0, 1'b0, 4'd3, 64'hC0FFEE, 1'b0, 1'b0);
      snap();
      send_range(0, tx_q.size() - 1);
      check_cnt("post_rst_fv", fv_total - fv_base, 1);
      check("post_rst_id", 64'(frame_id), 64'h7F0);
      check("post_rst_dlc", 64'(frame_dlc), 64'd3);
      check("post_rst_data", frame_data, 64'hC0FFEE);
      check_cnt("post_rst_ack_low_cycles", ack_low_total - ack_base, ACK_LOW);
      check_cnt("post_rst_errs", (crc_total - crc_base) + (stuff_total - stuff_base) + (form_total - form_base), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
